// File: rtl/i2c_arb_pkg.sv
// Shared constants for the two-domain I2C arbiter: FSM encoding, domain ids,
// default timing parameters and the round-robin pick helper.
package i2c_arb_pkg;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 3'd0;
  localparam arb_state_t ST_ISSUE   = 3'd1;
  localparam arb_state_t ST_WAIT    = 3'd2;
  localparam arb_state_t ST_DELIVER = 3'd3;
  localparam arb_state_t ST_GUARD   = 3'd4;

  localparam logic DOM_D1 = 1'b0;
  localparam logic DOM_D2 = 1'b1;

  localparam int unsigned DEF_GUARD_CYCLES   = 4;
  localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'hFFFF;

  // Under contention the domain that did not win last time is served.
  function automatic logic rr_pick(input logic req1, input logic req2,
                                   input logic last_grant);
    if (req1 && req2) return ~last_grant;
    else if (req2)    return DOM_D2;
    else              return DOM_D1;
  endfunction

endpackage

// File: rtl/i2c_arb_timer.sv
// 16-bit loadable down-counter shared by the WAIT timeout and the GUARD interval.
// 'last' flags the final counted cycle so the FSM leaves as the count expires.
module i2c_arb_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  output logic        zero,
  output logic        last
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 16'd0);
  assign last = (cnt_q == 16'd1);

endmodule

// File: rtl/i2c_domain_arbiter.sv
// Round-robin arbiter sharing one I2C read sequencer between domains D1 and D2,
// with a guard interval after every transaction before the domain may switch.
module i2c_domain_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES   = DEF_GUARD_CYCLES,
  parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_d1,
  input  logic [6:0] addr_d1,
  output logic       ack_d1,
  output logic       err_d1,
  output logic [7:0] data_d1,
  input  logic       req_d2,
  input  logic [6:0] addr_d2,
  output logic       ack_d2,
  output logic       err_d2,
  output logic [7:0] data_d2,
  output logic       sys_start,
  output logic [6:0] sys_slave_addr,
  input  logic       sys_done,
  input  logic [7:0] sys_rd_data,
  output logic       domain_i2c,
  output logic       busy
);

  arb_state_t  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        domain_q, domain_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  cap_q, cap_d;
  logic        err_q, err_d;

  logic        sys_start_q, sys_start_d;
  logic        ack_d1_q, ack_d1_d, ack_d2_q, ack_d2_d;
  logic        err_d1_q, err_d1_d, err_d2_q, err_d2_d;
  logic [7:0]  data_d1_q, data_d1_d, data_d2_q, data_d2_d;
  logic        busy_q, busy_d;

  logic        grant;
  logic        tmr_load, tmr_dec, tmr_zero, tmr_last;
  logic [15:0] tmr_load_val;
  logic        enter_deliver;

  i2c_arb_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero),
    .last     (tmr_last)
  );

  assign grant = rr_pick(req_d1, req_d2, last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    domain_d     = domain_q;
    addr_d       = addr_q;
    cap_d        = cap_q;
    err_d        = err_q;
    tmr_load     = 1'b0;
    tmr_load_val = 16'd0;
    tmr_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_d1 || req_d2) begin
          domain_d     = grant;
          last_grant_d = grant;
          addr_d       = (grant == DOM_D2) ? addr_d2 : addr_d1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_load     = 1'b1;
        tmr_load_val = TIMEOUT_CYCLES;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving in the expiring cycle still wins over the timeout.
        if (sys_done) begin
          cap_d   = sys_rd_data;
          err_d   = 1'b0;
          state_d = ST_DELIVER;
        end else if (tmr_zero || tmr_last) begin
          cap_d   = 8'h00;
          err_d   = 1'b1;
          state_d = ST_DELIVER;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_DELIVER: begin
        tmr_load     = 1'b1;
        tmr_load_val = 16'(GUARD_CYCLES);
        cap_d        = 8'h00;
        state_d      = ST_GUARD;
      end
      ST_GUARD: begin
        if (tmr_zero || tmr_last) begin
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    enter_deliver = (state_q == ST_WAIT) && (state_d == ST_DELIVER);
    sys_start_d   = (state_d == ST_ISSUE);
    busy_d        = (state_d != ST_IDLE);
    ack_d1_d      = enter_deliver && (domain_q == DOM_D1);
    ack_d2_d      = enter_deliver && (domain_q == DOM_D2);
    err_d1_d      = ack_d1_d && err_d;
    err_d2_d      = ack_d2_d && err_d;
    data_d1_d     = ack_d1_d ? cap_d : 8'h00;
    data_d2_d     = ack_d2_d ? cap_d : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= DOM_D2;
      domain_q     <= DOM_D1;
      addr_q       <= 7'h00;
      cap_q        <= 8'h00;
      err_q        <= 1'b0;
      sys_start_q  <= 1'b0;
      ack_d1_q     <= 1'b0;
      ack_d2_q     <= 1'b0;
      err_d1_q     <= 1'b0;
      err_d2_q     <= 1'b0;
      data_d1_q    <= 8'h00;
      data_d2_q    <= 8'h00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      domain_q     <= domain_d;
      addr_q       <= addr_d;
      cap_q        <= cap_d;
      err_q        <= err_d;
      sys_start_q  <= sys_start_d;
      ack_d1_q     <= ack_d1_d;
      ack_d2_q     <= ack_d2_d;
      err_d1_q     <= err_d1_d;
      err_d2_q     <= err_d2_d;
      data_d1_q    <= data_d1_d;
      data_d2_q    <= data_d2_d;
      busy_q       <= busy_d;
    end
  end

  assign sys_start      = sys_start_q;
  assign sys_slave_addr = addr_q;
  assign domain_i2c     = domain_q;
  assign busy           = busy_q;
  assign ack_d1         = ack_d1_q;
  assign ack_d2         = ack_d2_q;
  assign err_d1         = err_d1_q;
  assign err_d2         = err_d2_q;
  assign data_d1        = data_d1_q;
  assign data_d2        = data_d2_q;

endmodule

// File: tb/tb_i2c_domain_arbiter.sv
// Directed bench for i2c_domain_arbiter: a sequencer model answers starts, and a
// scoreboard queue of expected deliveries is checked against every ack.
module tb_i2c_domain_arbiter;

  localparam int          G_CYC  = 4;
  localparam logic [15:0] TO_CYC = 16'd50;

  typedef struct packed {
    logic       dom;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_d1, req_d2;
  logic [6:0] addr_d1, addr_d2;
  logic       ack_d1, ack_d2, err_d1, err_d2;
  logic [7:0] data_d1, data_d2;
  logic       sys_start, sys_done, domain_i2c, busy;
  logic [6:0] sys_slave_addr;
  logic [7:0] sys_rd_data;

  logic       model_done, force_done;
  logic [7:0] model_data, force_data;
  logic       seq_enable;
  int         seq_delay;
  logic       pend;
  int         pcnt;
  logic [6:0] paddr;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  logic       mon_en = 1'b0;
  logic       rst_s = 1'b0;
  logic       prev_domain = 1'b0;
  logic       prev_busy = 1'b0;
  int         n, lat;

  always #5 clk = ~clk;

  assign sys_done    = model_done | force_done;
  assign sys_rd_data = force_done ? force_data : model_data;

  i2c_domain_arbiter #(
    .GUARD_CYCLES   (G_CYC),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_d1         (req_d1),
    .addr_d1        (addr_d1),
    .ack_d1         (ack_d1),
    .err_d1         (err_d1),
    .data_d1        (data_d1),
    .req_d2         (req_d2),
    .addr_d2        (addr_d2),
    .ack_d2         (ack_d2),
    .err_d2         (err_d2),
    .data_d2        (data_d2),
    .sys_start      (sys_start),
    .sys_slave_addr (sys_slave_addr),
    .sys_done       (sys_done),
    .sys_rd_data    (sys_rd_data),
    .domain_i2c     (domain_i2c),
    .busy           (busy)
  );

  function automatic logic [7:0] seq_data(input logic [6:0] a);
    if (a == 7'h10)      return 8'h12;
    else if (a == 7'h20) return 8'h90;
    else                 return {1'b0, a} ^ 8'hA5;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic dom, input logic [7:0] data, input logic err);
    exp_t e;
    e.dom  = dom;
    e.data = data;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  task automatic wait_for_start(input int budget, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (sys_start !== 1'b1 && cnt < budget);
    check_output("start_seen", {31'b0, sys_start}, 32'd1);
  endtask

  task automatic wait_for_ack(input int budget, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (ack_d1 !== 1'b1 && ack_d2 !== 1'b1 && cnt < budget);
    check_output("ack_seen", {31'b0, (ack_d1 === 1'b1) || (ack_d2 === 1'b1)}, 32'd1);
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Sequencer model: answers each start seq_delay cycles later; it ignores
  // reset on purpose so a lost transaction produces a stray done.
  always @(negedge clk) begin
    model_done = 1'b0;
    model_data = 8'h00;
    if (pend) begin
      pcnt = pcnt - 1;
      if (pcnt == 0) begin
        model_done = 1'b1;
        model_data = seq_data(paddr);
        pend       = 1'b0;
      end
    end else if (sys_start === 1'b1 && seq_enable) begin
      pend  = 1'b1;
      pcnt  = seq_delay;
      paddr = sys_slave_addr;
    end
  end

  always @(posedge clk) rst_s <= rst;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (ack_d1 === 1'b1 || ack_d2 === 1'b1) begin
        check_output("ack_expected", {31'b0, sb_q.size() != 0}, 32'd1);
        check_output("ack_exclusive", {31'b0, ack_d1 & ack_d2}, 32'd0);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_output("ack_domain", {31'b0, ack_d2}, {31'b0, e.dom});
          check_output("ack_data", {24'b0, e.dom ? data_d2 : data_d1}, {24'b0, e.data});
          check_output("ack_err", {31'b0, e.dom ? err_d2 : err_d1}, {31'b0, e.err});
          check_output("other_data", {24'b0, e.dom ? data_d1 : data_d2}, 32'd0);
          check_output("other_err", {31'b0, e.dom ? err_d1 : err_d2}, 32'd0);
        end
      end else begin
        check_output("idle_data_d1", {24'b0, data_d1}, 32'd0);
        check_output("idle_data_d2", {24'b0, data_d2}, 32'd0);
        check_output("idle_err_d1", {31'b0, err_d1}, 32'd0);
        check_output("idle_err_d2", {31'b0, err_d2}, 32'd0);
      end
      if (domain_i2c !== prev_domain && !rst_s) begin
        check_output("domain_switch_idle", {31'b0, prev_busy}, 32'd0);
      end
    end
    prev_domain = domain_i2c;
    prev_busy   = busy;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    rst        = 1'b1;
    req_d1     = 1'b0;
    req_d2     = 1'b0;
    addr_d1    = 7'h00;
    addr_d2    = 7'h00;
    force_done = 1'b0;
    force_data = 8'h00;
    seq_enable = 1'b1;
    seq_delay  = 20;
    pend       = 1'b0;
    pcnt       = 0;
    paddr      = 7'h00;

    // Reset values
    idle_cycles(3);
    check_output("rst_sys_start", {31'b0, sys_start}, 32'd0);
    check_output("rst_ack_d1", {31'b0, ack_d1}, 32'd0);
    check_output("rst_ack_d2", {31'b0, ack_d2}, 32'd0);
    check_output("rst_busy", {31'b0, busy}, 32'd0);
    check_output("rst_addr", {25'b0, sys_slave_addr}, 32'd0);
    check_output("rst_domain", {31'b0, domain_i2c}, 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle_cycles(2);

    // Single D1 request
    $display("[TB] single D1 request");
    req_d1  = 1'b1;
    addr_d1 = 7'h10;
    push_exp(1'b0, 8'h12, 1'b0);
    wait_for_start(10, n);
    check_output("t1_start_latency", n, 32'd1);
    check_output("t1_addr", {25'b0, sys_slave_addr}, 32'h10);
    check_output("t1_domain", {31'b0, domain_i2c}, 32'd0);
    check_output("t1_busy", {31'b0, busy}, 32'd1);
    wait_for_ack(100, lat);
    req_d1 = 1'b0;
    check_output("t1_ack_latency", lat, 32'(seq_delay + 1));
    check_output("t1_ack_d2_quiet", {31'b0, ack_d2}, 32'd0);
    @(negedge clk);
    check_output("t1_ack_one_cycle", {31'b0, ack_d1}, 32'd0);
    idle_cycles(10);

    // Simultaneous requests after reset
    $display("[TB] simultaneous requests after reset");
    rst = 1'b1;
    idle_cycles(2);
    rst     = 1'b0;
    @(negedge clk);
    req_d1  = 1'b1;
    addr_d1 = 7'h10;
    req_d2  = 1'b1;
    addr_d2 = 7'h20;
    push_exp(1'b0, 8'h12, 1'b0);
    push_exp(1'b1, 8'h90, 1'b0);
    wait_for_start(10, n);
    check_output("t2_first_addr", {25'b0, sys_slave_addr}, 32'h10);
    check_output("t2_first_domain", {31'b0, domain_i2c}, 32'd0);
    wait_for_ack(100, lat);
    req_d1 = 1'b0;
    wait_for_start(40, n);
    check_output("t2_start_spacing", n, 32'(G_CYC + 2));
    check_output("t2_second_addr", {25'b0, sys_slave_addr}, 32'h20);
    check_output("t2_second_domain", {31'b0, domain_i2c}, 32'd1);
    wait_for_ack(100, lat);
    req_d2 = 1'b0;
    idle_cycles(10);

    // Continuous dual requests: strict alternation
    $display("[TB] continuous dual requests");
    req_d1 = 1'b1;
    req_d2 = 1'b1;
    for (int i = 0; i < 6; i++) push_exp(i[0], i[0] ? 8'h90 : 8'h12, 1'b0);
    for (int i = 0; i < 6; i++) begin
      wait_for_ack(100, lat);
      check_output("t3_grant_order", {31'b0, ack_d2}, {31'b0, i[0]});
    end
    req_d1 = 1'b0;
    req_d2 = 1'b0;
    idle_cycles(10);

    // Timeout: sequencer silent
    $display("[TB] timeout");
    seq_enable = 1'b0;
    req_d2     = 1'b1;
    addr_d2    = 7'h33;
    push_exp(1'b1, 8'h00, 1'b1);
    wait_for_start(10, n);
    check_output("t4_domain", {31'b0, domain_i2c}, 32'd1);
    wait_for_ack(200, lat);
    req_d2 = 1'b0;
    check_output("t4_ack_latency", lat, 32'(TO_CYC) + 32'd1);
    check_output("t4_err_d2", {31'b0, err_d2}, 32'd1);
    idle_cycles(10);
    seq_enable = 1'b1;

    // Reset mid-WAIT, then the stray done must be ignored
    $display("[TB] reset mid-WAIT");
    req_d1  = 1'b1;
    addr_d1 = 7'h10;
    wait_for_start(10, n);
    idle_cycles(10);
    rst    = 1'b1;
    req_d1 = 1'b0;
    @(negedge clk);
    check_output("t5_busy", {31'b0, busy}, 32'd0);
    check_output("t5_ack_d1", {31'b0, ack_d1}, 32'd0);
    check_output("t5_sys_start", {31'b0, sys_start}, 32'd0);
    check_output("t5_addr", {25'b0, sys_slave_addr}, 32'd0);
    check_output("t5_domain", {31'b0, domain_i2c}, 32'd0);
    rst = 1'b0;
    idle_cycles(20);
    check_output("t5_busy_after_stray", {31'b0, busy}, 32'd0);

    // Spurious done in IDLE and in GUARD
    $display("[TB] spurious done");
    force_data = 8'hAA;
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    check_output("t6_idle_busy", {31'b0, busy}, 32'd0);
    check_output("t6_idle_start", {31'b0, sys_start}, 32'd0);
    req_d2  = 1'b1;
    addr_d2 = 7'h20;
    push_exp(1'b1, 8'h90, 1'b0);
    wait_for_ack(100, lat);
    req_d2  = 1'b0;
    req_d1  = 1'b1;
    addr_d1 = 7'h10;
    push_exp(1'b0, 8'h12, 1'b0);
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    check_output("t6_guard_busy", {31'b0, busy}, 32'd1);
    wait_for_start(40, n);
    check_output("t6_start_spacing", n + 2, 32'(G_CYC + 2));
    check_output("t6_addr", {25'b0, sys_slave_addr}, 32'h10);
    wait_for_ack(100, lat);
    req_d1 = 1'b0;
    idle_cycles(10);

    check_output("scoreboard_drained", sb_q.size(), 32'd0);
    check_output("final_busy", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
